// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage with a single outstanding memory request.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   stall               decode hazard: hold pc and if_id
//   flush               decode taken-branch: squash the instruction in IF
//   PCsrc, pc_b         redirect request and its target (pc_b[1:0] ignored)
//   imem_req, imem_addr instruction memory request and word address
//   imem_ack, imem_rdata memory response (zero or more wait cycles)
//   if_id               registered {pc+4, instr} to decode
//
// FETCH/WAIT keep a request to pc open until ack. DROP keeps a request open
// at the pre-redirect address so its late data can be thrown away. HOLD
// parks a word that arrived while decode was stalled.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        PCsrc,
   input  logic [31:0] pc_b,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [63:0] if_id
);

   typedef enum logic [1:0] {FETCH, WAIT, DROP, HOLD} state_t;

   localparam logic [63:0] BUBBLE = {32'h0, NOP_WORD};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc4_q, hold_pc4_d;
   logic [63:0] if_id_q, if_id_d;

   logic        redirect;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic [31:0] addr_sel;

   assign redirect = PCsrc | flush;
   assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32
   // flush alone skips the squashed instruction; PCsrc jumps to the aligned target
   assign target   = PCsrc ? (pc_b & 32'hFFFF_FFFC) : pc_plus4;

   // DROP must keep presenting the abandoned address until its ack arrives
   assign addr_sel  = (state_q == DROP) ? drop_addr_q : pc_q;
   assign imem_addr = {addr_sel[31:2], 2'b00};
   assign imem_req  = ~rst & (state_q != HOLD);
   assign if_id     = if_id_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      if_id_d      = if_id_q;
      case (state_q)
         FETCH, WAIT: begin
            if (redirect) begin
               if_id_d = BUBBLE;
               pc_d    = target;
               if (imem_ack) begin
                  state_d = FETCH;       // returned word is simply not used
               end else begin
                  state_d     = DROP;
                  drop_addr_d = pc_q;
               end
            end else if (imem_ack && !stall) begin
               if_id_d = {pc_plus4, imem_rdata};
               pc_d    = pc_plus4;
               state_d = FETCH;
            end else if (imem_ack) begin
               // pc advances only when the held word is released to decode
               hold_instr_d = imem_rdata;
               hold_pc4_d   = pc_plus4;
               state_d      = HOLD;
            end else begin
               if (!stall) if_id_d = BUBBLE;
               state_d = WAIT;
            end
         end
         DROP: begin
            if_id_d = BUBBLE;
            if (redirect) pc_d = target;   // newest target wins
            if (imem_ack) state_d = FETCH;
         end
         HOLD: begin
            if (redirect) begin
               if_id_d = BUBBLE;
               pc_d    = target;
               state_d = FETCH;
            end else if (!stall) begin
               if_id_d = {hold_pc4_q, hold_instr_q};
               pc_d    = pc_plus4;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC & 32'hFFFF_FFFC;
         drop_addr_q  <= 32'h0;
         hold_instr_q <= 32'h0;
         hold_pc4_q   <= 32'h0;
         if_id_q      <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         if_id_q      <= if_id_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized + directed stimulus against a transaction-level
// reference model; expected if_id values are queued by the driver and
// compared by an independent monitor after each clock edge.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;
   localparam logic [63:0] BUBBLE   = {32'h0, NOP_WORD};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, PCsrc = 1'b0;
   logic [31:0] pc_b = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [63:0] if_id;

   instr_fetch #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .PCsrc(PCsrc),
      .pc_b(pc_b), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id(if_id));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] exp_q[$];

   // reference model: pc, an in-flight request being discarded, a parked word
   logic [31:0] m_pc;
   logic        m_drain;
   logic [31:0] m_daddr;
   logic        m_held;
   logic [31:0] m_hinstr, m_hpc4;
   logic [63:0] m_ifid;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RESET_PC; m_drain = 1'b0; m_daddr = 32'h0;
      m_held = 1'b0; m_hinstr = 32'h0; m_hpc4 = 32'h0; m_ifid = 64'h0;
   endtask

   // one clock of stimulus: drive, check the request side, advance the model
   task automatic cycle(input logic s, input logic f, input logic p,
                        input logic [31:0] b, input logic a);
      logic        req, ack, redir;
      logic [31:0] addr, data, tgt;
      @(negedge clk);
      req  = !m_held;
      addr = m_drain ? m_daddr : m_pc;
      ack  = a & req;
      data = mem_word(addr);
      stall = s; flush = f; PCsrc = p; pc_b = b;
      imem_ack = ack; imem_rdata = ack ? data : 32'hDEAD_BEEF;
      #1;
      chk("imem_req", {63'h0, imem_req}, {63'h0, req});
      if (req) chk("imem_addr", {32'h0, imem_addr}, {32'h0, addr});
      redir = p | f;
      tgt   = p ? {b[31:2], 2'b00} : m_pc + 32'd4;
      if (redir) begin
         m_ifid = BUBBLE;
         if (m_held) m_held = 1'b0;
         else if (m_drain) begin if (ack) m_drain = 1'b0; end
         else if (!ack) begin m_drain = 1'b1; m_daddr = m_pc; end
         m_pc = tgt;
      end else if (m_held) begin
         if (!s) begin m_ifid = {m_hpc4, m_hinstr}; m_pc = m_pc + 32'd4; m_held = 1'b0; end
      end else if (m_drain) begin
         m_ifid = BUBBLE;
         if (ack) m_drain = 1'b0;
      end else if (ack) begin
         if (s) begin m_held = 1'b1; m_hinstr = data; m_hpc4 = m_pc + 32'd4; end
         else begin m_ifid = {m_pc + 32'd4, data}; m_pc = m_pc + 32'd4; end
      end else if (!s) m_ifid = BUBBLE;
      exp_q.push_back(m_ifid);
   endtask

   // monitor: registered output compared just after each edge
   always @(posedge clk) begin
      logic [63:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("if_id", if_id, e);
      end
   end

   initial begin
      model_reset();
      #1;
      chk("reset if_id", if_id, 64'h0);
      chk("reset req", {63'h0, imem_req}, 64'h0);
      chk("reset addr", {32'h0, imem_addr}, {32'h0, RESET_PC});
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // zero-wait stream from 0,4,8
      repeat (3) cycle(0, 0, 0, 32'h0, 1);
      // two wait states then data
      cycle(0, 0, 0, 32'h0, 0); cycle(0, 0, 0, 32'h0, 0); cycle(0, 0, 0, 32'h0, 1);
      // ack under stall -> parked, then released
      cycle(1, 0, 0, 32'h0, 1); cycle(1, 0, 0, 32'h0, 1); cycle(0, 0, 0, 32'h0, 0);
      cycle(0, 0, 0, 32'h0, 1);
      // redirect while request outstanding -> DROP, retarget in DROP
      cycle(0, 0, 0, 32'h0, 0);
      cycle(0, 0, 1, 32'h40, 0); cycle(0, 0, 0, 32'h0, 0);
      cycle(0, 0, 1, 32'h43, 0); cycle(0, 0, 0, 32'h0, 1);
      cycle(0, 0, 0, 32'h0, 1);
      // redirect beats stall, also out of HOLD
      cycle(1, 0, 1, 32'h80, 1);
      cycle(1, 0, 0, 32'h0, 1); cycle(1, 0, 1, 32'h80, 0); cycle(0, 0, 0, 32'h0, 1);
      // flush alone, redirect coincident with ack
      cycle(0, 1, 0, 32'h0, 1); cycle(0, 0, 1, 32'h100, 1); cycle(0, 0, 0, 32'h0, 1);
      // pc wrap
      cycle(0, 0, 1, 32'hFFFF_FFFC, 0); cycle(0, 0, 0, 32'h0, 1); cycle(0, 0, 0, 32'h0, 1);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] b;
         b = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, b, $urandom_range(0, 9) < 6);
      end

      // asynchronous reset in the middle of a wait
      cycle(0, 0, 1, 32'h200, 1);
      cycle(0, 0, 0, 32'h0, 0);
      @(negedge clk);
      stall = 0; flush = 0; PCsrc = 0; imem_ack = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst if_id", if_id, 64'h0);
      chk("async rst req", {63'h0, imem_req}, 64'h0);
      chk("async rst pc", {32'h0, imem_addr}, {32'h0, RESET_PC});
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;   // late ack while in reset
      @(negedge clk); @(negedge clk);
      rst = 1'b0; imem_ack = 1'b0;
      model_reset();
      cycle(0, 0, 0, 32'h0, 1); cycle(0, 0, 0, 32'h0, 1);

      @(negedge clk); @(negedge clk);
      chk("queue drained", {32'h0, exp_q.size()}, 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
